// File: rtl/option_pkg.sv
// ---------------------------------------------------------------------------
// option_pkg
// Shared definitions for the Monte-Carlo option pricing slice (Path_Gen and
// payoff_averager): mode encodings, fixed-point fraction widths, the
// averager state enum and the 16-bit Q8.8 price type.
// ---------------------------------------------------------------------------
package option_pkg;

    // Option mode encoding: bit 1 selects Asian (arithmetic mean of the
    // samples), bit 0 selects put.
    localparam logic [1:0] MODE_EURO_CALL  = 2'b00;
    localparam logic [1:0] MODE_EURO_PUT   = 2'b01;
    localparam logic [1:0] MODE_ASIAN_CALL = 2'b10;
    localparam logic [1:0] MODE_ASIAN_PUT  = 2'b11;

    // Fixed-point formats: prices are unsigned Q8.8, discount is Q1.15.
    localparam int Q88_FRAC  = 8;
    localparam int Q115_FRAC = 15;
    localparam int PRICE_W   = 2 * Q88_FRAC;

    typedef logic [PRICE_W-1:0] price_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_SCALE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    function automatic logic mode_is_asian(input logic [1:0] mode);
        return mode[1];
    endfunction

endpackage

// File: rtl/payoff_calc.sv
// ---------------------------------------------------------------------------
// payoff_calc
// Combinational option payoff for one path.
//   value  in  16  path value V (final sample or path mean), Q8.8
//   strike in  16  strike K, Q8.8
//   mode   in  2   option mode (only bit 0, call/put, matters here)
//   payoff out 16  max(V-K,0) for calls, max(K-V,0) for puts, Q8.8
// ---------------------------------------------------------------------------
module payoff_calc
    import option_pkg::*;
(
    input  price_t     value,
    input  price_t     strike,
    input  logic [1:0] mode,
    output price_t     payoff
);

    // 17-bit signed difference so that V-K never overflows; a negative
    // result means the option is out of the money and pays nothing.
    logic signed [PRICE_W:0] diff;

    always_comb begin
        diff = '0;
        unique case (mode)
            MODE_EURO_CALL, MODE_ASIAN_CALL:
                diff = $signed({1'b0, value}) - $signed({1'b0, strike});
            MODE_EURO_PUT, MODE_ASIAN_PUT:
                diff = $signed({1'b0, strike}) - $signed({1'b0, value});
            default:
                diff = '0;
        endcase
    end

    assign payoff = diff[PRICE_W] ? '0 : diff[PRICE_W-1:0];

endmodule

// File: rtl/payoff_averager.sv
// ---------------------------------------------------------------------------
// payoff_averager
// Monte-Carlo pricing back end. Consumes Path_Gen samples, forms the per-path
// value (final sample or arithmetic mean), converts it to a payoff, sums the
// payoffs over 2^PATHS_LOG2 paths and outputs the discounted mean as price.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        one-cycle pulse in IDLE; latches mode/strike/disc
//   mode         00 Euro call, 01 Euro put, 10 Asian call, 11 Asian put
//   strike       strike K, Q8.8
//   disc         discount factor, Q1.15 (0x8000 = 1.0)
//   path_valid   sample qualifier for path
//   path         price sample S, Q8.8
//   busy         high from the cycle after start until done
//   done         one-cycle pulse, price valid
//   price        discounted mean payoff, Q8.8, held until next done
//
// Handshake: path_valid is a pure valid with no ready; every cycle with
// path_valid high in RUN is one accepted sample. Samples in IDLE, SCALE and
// DONE are dropped, as is start outside IDLE.
// ---------------------------------------------------------------------------
module payoff_averager
    import option_pkg::*;
#(
    parameter int STEPS_LOG2 = 4,
    parameter int PATHS_LOG2 = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  mode,
    input  logic [15:0] strike,
    input  logic [15:0] disc,
    input  logic        path_valid,
    input  logic [15:0] path,
    output logic        busy,
    output logic        done,
    output logic [15:0] price
);

    state_t state, state_next;

    logic [1:0]                  mode_q;
    price_t                      strike_q;
    logic [15:0]                 disc_q;
    logic [STEPS_LOG2-1:0]       step_cnt;
    logic [PATHS_LOG2-1:0]       path_cnt;
    logic [16+STEPS_LOG2-1:0]    step_sum;
    logic [16+PATHS_LOG2-1:0]    total;
    price_t                      path_value;
    logic                        pv_valid;

    logic                        accept;
    logic                        last_step;
    logic                        last_add;
    logic [16+STEPS_LOG2-1:0]    sum_next;
    price_t                      asian_value;
    price_t                      payoff;
    logic [15:0]                 mean;
    logic [16:0]                 scaled;
    price_t                      price_next;

    assign accept    = (state == S_RUN) && path_valid;
    assign last_step = (step_cnt == '1);
    // The payoff registered this cycle belongs to the last path of the batch.
    assign last_add  = pv_valid && (path_cnt == '1);

    // The mean includes the sample arriving on the last step, so the sum is
    // taken from the adder output rather than the registered step sum.
    assign sum_next    = step_sum + {{STEPS_LOG2{1'b0}}, path};
    assign asian_value = sum_next[STEPS_LOG2 +: 16];

    payoff_calc u_payoff_calc (
        .value  (path_value),
        .strike (strike_q),
        .mode   (mode_q),
        .payoff (payoff)
    );

    // Discounted mean: Q8.8 x Q1.15 gives Q9.23 in 32 bits; dropping 15
    // fraction bits leaves a 17-bit Q9.8 that saturates into 16 bits.
    assign mean       = 16'(total >> PATHS_LOG2);
    assign scaled     = 17'((32'(mean) * 32'(disc_q)) >> Q115_FRAC);
    assign price_next = scaled[16] ? '1 : scaled[15:0];

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:  if (start) state_next = S_RUN;
            S_RUN:   if (last_add) state_next = S_SCALE;
            S_SCALE: state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy = (state != S_IDLE);
        done = (state == S_DONE);
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q     <= '0;
            strike_q   <= '0;
            disc_q     <= '0;
            step_cnt   <= '0;
            path_cnt   <= '0;
            step_sum   <= '0;
            total      <= '0;
            path_value <= '0;
            pv_valid   <= 1'b0;
            price      <= '0;
        end else if ((state == S_IDLE) && start) begin
            mode_q     <= mode;
            strike_q   <= strike;
            disc_q     <= disc;
            step_cnt   <= '0;
            path_cnt   <= '0;
            step_sum   <= '0;
            total      <= '0;
            pv_valid   <= 1'b0;
        end else begin
            pv_valid <= 1'b0;

            // Stage 1: per-step accumulation; the wrap step registers the
            // path value and restarts the sum for the next path.
            if (accept) begin
                step_cnt <= step_cnt + STEPS_LOG2'(1);
                if (last_step) begin
                    step_sum   <= '0;
                    pv_valid   <= 1'b1;
                    path_value <= mode_is_asian(mode_q) ? asian_value : path;
                end else begin
                    step_sum <= sum_next;
                end
            end

            // Stage 2: payoff accumulation, independent of stage 1 so a new
            // sample can arrive in the same cycle.
            if (pv_valid) begin
                total    <= total + {{PATHS_LOG2{1'b0}}, payoff};
                path_cnt <= path_cnt + PATHS_LOG2'(1);
            end

            if (state == S_SCALE) begin
                price <= price_next;
            end
        end
    end

endmodule

// File: tb/tb_payoff_averager.sv
// ---------------------------------------------------------------------------
// tb_payoff_averager
// Directed bench for payoff_averager with STEPS_LOG2=2, PATHS_LOG2=2
// (4 samples per path, 4 paths per batch). Inputs change on the falling
// edge; outputs are checked on the falling edge.
// ---------------------------------------------------------------------------
module tb_payoff_averager;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  mode;
    logic [15:0] strike;
    logic [15:0] disc;
    logic        path_valid;
    logic [15:0] path;
    logic        busy;
    logic        done;
    logic [15:0] price;

    int n_checks;
    int n_pass;

    logic [15:0] smp [16];

    payoff_averager #(
        .STEPS_LOG2 (2),
        .PATHS_LOG2 (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .mode       (mode),
        .strike     (strike),
        .disc       (disc),
        .path_valid (path_valid),
        .path       (path),
        .busy       (busy),
        .done       (done),
        .price      (price)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
    endtask

    // Euro paths: only the last sample of each path matters; the other
    // three are random fillers.
    task automatic fill_euro(input logic [15:0] f0, input logic [15:0] f1,
                             input logic [15:0] f2, input logic [15:0] f3);
        for (int i = 0; i < 16; i++) smp[i] = 16'($urandom_range(0, 16'hFFFF));
        smp[3]  = f0;
        smp[7]  = f1;
        smp[11] = f2;
        smp[15] = f3;
    endtask

    task automatic fill_const(input logic [15:0] s0, input logic [15:0] s1,
                              input logic [15:0] s2, input logic [15:0] s3);
        for (int p = 0; p < 4; p++) begin
            smp[p*4+0] = s0;
            smp[p*4+1] = s1;
            smp[p*4+2] = s2;
            smp[p*4+3] = s3;
        end
    endtask

    // Called on a falling edge in IDLE; returns on the falling edge of S+1.
    task automatic start_batch(input logic [1:0] m, input logic [15:0] k,
                               input logic [15:0] d, input string tag);
        start  = 1'b1;
        mode   = m;
        strike = k;
        disc   = d;
        @(negedge clk);
        start  = 1'b0;
        mode   = 2'($urandom_range(0, 3));
        strike = 16'($urandom_range(0, 16'hFFFF));
        disc   = 16'($urandom_range(0, 16'hFFFF));
        chk({tag, " busy at S+1"}, {15'd0, busy}, 16'd1);
    endtask

    // Feeds smp[lo..hi]; optional random idle gaps before every sample but
    // the first. Returns on the falling edge after the last accepted sample.
    task automatic feed(input int lo, input int hi, input int max_gap);
        for (int i = lo; i <= hi; i++) begin
            if (max_gap > 0 && i != lo) begin
                repeat ($urandom_range(0, max_gap)) @(negedge clk);
            end
            path_valid = 1'b1;
            path       = smp[i];
            @(negedge clk);
            path_valid = 1'b0;
            path       = 16'($urandom_range(0, 16'hFFFF));
        end
    endtask

    // Entered on the falling edge of T+1 (last sample accepted at T).
    task automatic finish_batch(input logic [15:0] exp_price, input string tag);
        chk({tag, " done T+1"}, {15'd0, done}, 16'd0);
        @(negedge clk);
        chk({tag, " done T+2"}, {15'd0, done}, 16'd0);
        @(negedge clk);
        chk({tag, " done T+3"}, {15'd0, done}, 16'd1);
        chk({tag, " busy T+3"}, {15'd0, busy}, 16'd1);
        chk({tag, " price"}, price, exp_price);
        @(negedge clk);
        chk({tag, " done T+4"}, {15'd0, done}, 16'd0);
        chk({tag, " busy T+4"}, {15'd0, busy}, 16'd0);
        chk({tag, " price held"}, price, exp_price);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic seen_done;
        n_checks   = 0;
        n_pass     = 0;
        rst_n      = 1'b0;
        start      = 1'b0;
        mode       = 2'b00;
        strike     = 16'h0000;
        disc       = 16'h0000;
        path_valid = 1'b0;
        path       = 16'h0000;

        repeat (2) @(negedge clk);
        chk("reset busy", {15'd0, busy}, 16'd0);
        chk("reset done", {15'd0, done}, 16'd0);
        chk("reset price", price, 16'h0000);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Euro call: payoffs 10, 0, 20, 0 -> mean 7.5
        fill_euro(16'h6E00, 16'h5A00, 16'h7800, 16'h6400);
        start_batch(2'b00, 16'h6400, 16'h8000, "euro_call");
        feed(0, 15, 0);
        finish_batch(16'h0780, "euro_call");

        // Samples while IDLE must be dropped.
        fill_const(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        feed(0, 5, 0);
        chk("idle samples busy", {15'd0, busy}, 16'd0);

        // Euro put: payoffs 0, 10, 0, 0 -> mean 2.5
        fill_euro(16'h6E00, 16'h5A00, 16'h7800, 16'h6400);
        start_batch(2'b01, 16'h6400, 16'h8000, "euro_put");
        feed(0, 15, 0);
        finish_batch(16'h0280, "euro_put");

        // Asian call: path mean 102.0, payoff 2.0 on every path
        fill_const(16'h6000, 16'h6400, 16'h6800, 16'h6C00);
        start_batch(2'b10, 16'h6400, 16'h8000, "asian_call");
        feed(0, 15, 0);
        finish_batch(16'h0200, "asian_call");

        // Discount 0.5 on the Euro call: 7.5 * 0.5 = 3.75
        fill_euro(16'h6E00, 16'h5A00, 16'h7800, 16'h6400);
        start_batch(2'b00, 16'h6400, 16'h4000, "disc_half");
        feed(0, 15, 0);
        finish_batch(16'h03C0, "disc_half");

        // Saturation: mean 0xFFFF times ~2.0 overflows 16 bits
        fill_const(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        start_batch(2'b00, 16'h0000, 16'hFFFF, "saturate");
        feed(0, 15, 0);
        finish_batch(16'hFFFF, "saturate");

        // Random path_valid gaps give the same price as back-to-back
        fill_euro(16'h6E00, 16'h5A00, 16'h7800, 16'h6400);
        start_batch(2'b00, 16'h6400, 16'h8000, "gaps");
        feed(0, 15, 3);
        finish_batch(16'h0780, "gaps");

        // start during RUN with different settings is ignored
        fill_euro(16'h6E00, 16'h5A00, 16'h7800, 16'h6400);
        start_batch(2'b00, 16'h6400, 16'h8000, "start_in_run");
        feed(0, 5, 0);
        start  = 1'b1;
        mode   = 2'b01;
        strike = 16'h0000;
        disc   = 16'h4000;
        @(negedge clk);
        start  = 1'b0;
        chk("start_in_run busy", {15'd0, busy}, 16'd1);
        feed(6, 15, 0);
        finish_batch(16'h0780, "start_in_run");

        // Reset after two paths, then a fresh put batch
        fill_euro(16'h6E00, 16'h5A00, 16'h7800, 16'h6400);
        start_batch(2'b00, 16'h6400, 16'h8000, "mid_reset");
        feed(0, 7, 0);
        rst_n = 1'b0;
        #1;
        chk("mid_reset busy", {15'd0, busy}, 16'd0);
        chk("mid_reset done", {15'd0, done}, 16'd0);
        chk("mid_reset price", price, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        chk("mid_reset no stale done", {15'd0, seen_done}, 16'd0);
        chk("mid_reset idle", {15'd0, busy}, 16'd0);
        start_batch(2'b01, 16'h6400, 16'h8000, "after_reset");
        feed(0, 15, 0);
        finish_batch(16'h0280, "after_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
